msi_directory_controller: RTL and testbench
===========================================

# msi_directory_controller

Home-node directory controller for the two-processor MSI coherence system. It accepts one read or write request at a time from the L1s of P0,0 and P0,1, looks up the per-block directory entry, and issues invalidate or fetch messages to the other L1 with an ack handshake. It then updates directory state and home memory and returns a single-cycle response. It sits between the request stimulus/L1 request path and the L1 coherence-message ports. It uses the same 4-bit address/data codes and 2-bit op/processor codes as the rest of the MSI test system.

## Interface
- NBLK, 9: directory/memory entries, indexed by address code 0..8.
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high; clears all state.
- ReqValid  in  1  request present.
- ReqReady  out  1  controller can accept; high only in IDLE.
- ReqAddr  in  4  block code; 1..8 valid, 0 = empty.
- ReqOp  in  2  00 read, 01 write; 1x is illegal.
- ReqProc  in  2  00 P0,0, 01 P0,1; 1x is illegal.
- ReqData  in  4  write data code; ignored on reads.
- MsgValid  out  1  coherence message to an L1; held until acked.
- MsgType  out  2  01 Invalidate, 10 Fetch, 11 FetchInvalidate, 00 none.
- MsgProc  out  2  target L1.
- MsgAddr  out  4  block code.
- MsgAck  in  1  target L1 done; sampled only while MsgValid=1.
- MsgData  in  4  block data from the owner; valid with MsgAck on Fetch and FetchInvalidate.
- RespValid  out  1  one-cycle response pulse; no back-pressure.
- RespProc  out  2  requester.
- RespData  out  4  block data after the operation.
- RespGrant  out  2  state granted to the requester: 01 S, 10 M.
- RespErr  out  1  illegal request; no state change.

## Operation
- Per-entry state: dstate[1:0] (00 U, 01 S, 10 M), sharers[1:0] (bit p = processor p), mem[3:0].
- In state M, exactly one sharer bit is set; that processor is the owner.
- FSM states: IDLE → LOOKUP → (SEND_MSG → WAIT_ACK) → UPDATE → RESP → IDLE. SEND_MSG is skipped when no message is needed.
- Let p be the requester and q be the other processor.
- Read, U: state S, sharers={p}, no message.
- Read, S: sharers|={p}, no message.
- Read, M with owner q: send Fetch to q. On ack, mem←MsgData, state S, sharers={p,q}.
- Read, M with owner p: no message, no change, grant M.
- Write, U: state M, sharers={p}.
- Write, S with q in sharers: send Invalidate to q. After ack, state M, sharers={p}.
- Write, S with p the only sharer: no message, state M.
- Write, M with owner q: send FetchInvalidate to q. On ack, mem←MsgData, then apply the write, owner p.
- Write, M with owner p: no message, no change.
- Every write sets mem←ReqData in UPDATE, after any MsgData capture in the same transaction.
- RespData = mem value after UPDATE.
- Illegal request (addr 0 or >8, op 1x, proc 1x): follows IDLE→LOOKUP→RESP with RespErr=1, RespData=0, RespGrant=00. No message is sent and no state changes.

## Timing
- Accept on the posedge where ReqValid & ReqReady = 1 (cycle N). Request fields are latched at N; later changes on the inputs are ignored.
- No-message path: LOOKUP at N+1, UPDATE at N+2, RespValid=1 at N+3, ReqReady=1 again at N+4.
- Message path: MsgValid=1 from N+2. Msg* outputs are stable until the cycle A in which MsgAck=1; A=N+2 is allowed.
- After the ack: MsgValid=0 at A+1 (UPDATE), RespValid=1 at A+2, IDLE at A+3.
- Illegal-request path: RespValid=1 at N+2.
- MsgAck while MsgValid=0 is ignored. ReqValid outside IDLE is not accepted.
- Reset values: ReqReady=1 after the reset cycle. MsgValid, RespValid and RespErr are 0; MsgType, MsgProc, MsgAddr, RespProc, RespData and RespGrant are 0. All entries are U with sharers=00 and mem=0.
- Reset asserted mid-transaction: the transaction is aborted. All outputs return to reset values on the next edge, no response is issued, and the directory is cleared.

## Test plan
- After reset, P0,0 reads addr 1 at cycle N → RespValid at N+3, RespData=0, RespGrant=S; entry 1 is S with sharers=01; no MsgValid.
- P0,0 reads addr 6, then P0,0 writes addr 6 with data 7 → write produces no message, RespGrant=M, mem[6]=7, sharers=01.
- P0,0 and P0,1 both read addr 5; P0,1 then writes 8 → Invalidate to P0,0 for addr 5. Ack held off 3 cycles; RespValid at A+2; mem[5]=8; owner P0,1.
- P0,0 writes 9 to addr 5 → FetchInvalidate to P0,1; ack with MsgData=8; mem[5]=9; owner P0,0.
- P0,1 then reads addr 5 → Fetch to P0,0; ack with MsgData=9; RespData=9, state S, sharers=11.
- Request with addr 0 → RespErr=1 at N+2, no message, directory unchanged. Reset asserted during WAIT_ACK → MsgValid=0 next cycle, no RespValid, all entries U.

Source files
------------

// File: rtl/msi_directory_controller.sv
// Home-node MSI directory for two L1s: one request at a time, optional
// invalidate/fetch handshake with the peer L1, then directory/memory update and a one-cycle response.
module msi_directory_controller #(
    parameter int NBLK = 9
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ReqValid,
    output logic       ReqReady,
    input  logic [3:0] ReqAddr,
    input  logic [1:0] ReqOp,
    input  logic [1:0] ReqProc,
    input  logic [3:0] ReqData,
    output logic       MsgValid,
    output logic [1:0] MsgType,
    output logic [1:0] MsgProc,
    output logic [3:0] MsgAddr,
    input  logic       MsgAck,
    input  logic [3:0] MsgData,
    output logic       RespValid,
    output logic [1:0] RespProc,
    output logic [3:0] RespData,
    output logic [1:0] RespGrant,
    output logic       RespErr
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        SEND_MSG,
        WAIT_ACK,
        UPDATE,
        RESP
    } state_t;

    localparam logic [1:0] ST_U      = 2'b00;
    localparam logic [1:0] ST_S      = 2'b01;
    localparam logic [1:0] ST_M      = 2'b10;
    localparam logic [1:0] MSG_NONE  = 2'b00;
    localparam logic [1:0] MSG_INV   = 2'b01;
    localparam logic [1:0] MSG_FETCH = 2'b10;
    localparam logic [1:0] MSG_FINV  = 2'b11;
    localparam logic [1:0] OP_RD     = 2'b00;
    localparam logic [1:0] GRANT_S   = 2'b01;
    localparam logic [1:0] GRANT_M   = 2'b10;

    state_t state, state_nx;

    logic [1:0] dstate  [NBLK];
    logic [1:0] sharers [NBLK];
    logic [3:0] mem     [NBLK];

    logic [3:0] req_addr_p0;
    logic [3:0] req_data_p0;
    logic [1:0] req_op_p0;
    logic [1:0] req_proc_p0;
    logic       err_p1;
    logic [1:0] msg_type_p1;
    logic [3:0] cap_data_p2;
    logic       cap_vld_p2;
    logic [3:0] resp_data;
    logic [1:0] resp_grant;

    logic       illegal;
    logic [3:0] idx;
    logic       p;
    logic       peer;
    logic [1:0] p_mask;
    logic [1:0] cur_st;
    logic [1:0] cur_sh;
    logic       peer_has;
    logic [1:0] msg_nx;
    logic [1:0] new_st;
    logic [1:0] new_sh;
    logic [3:0] new_mem;
    logic [1:0] new_grant;
    logic [3:0] base_mem;
    logic       msg_on;
    logic       resp_on;

    // Directory lookup and message decision on the latched request
    always_comb begin
        illegal  = (req_addr_p0 == 4'd0) || (req_addr_p0 > 4'(NBLK - 1)) ||
                   req_op_p0[1] || req_proc_p0[1];
        idx      = illegal ? 4'd0 : req_addr_p0;
        p        = req_proc_p0[0];
        peer     = ~p;
        p_mask   = p ? 2'b10 : 2'b01;
        cur_st   = dstate[idx];
        cur_sh   = sharers[idx];
        peer_has = cur_sh[peer];
        msg_nx   = MSG_NONE;
        if (req_op_p0 == OP_RD) begin
            if (cur_st == ST_M && peer_has) msg_nx = MSG_FETCH;
        end else begin
            if (cur_st == ST_S && peer_has) msg_nx = MSG_INV;
            else if (cur_st == ST_M && peer_has) msg_nx = MSG_FINV;
        end
    end

    // New entry contents; owner data captured on the ack lands before any write data
    always_comb begin
        base_mem  = cap_vld_p2 ? cap_data_p2 : mem[idx];
        new_st    = cur_st;
        new_sh    = cur_sh;
        new_mem   = base_mem;
        new_grant = GRANT_S;
        if (req_op_p0 != OP_RD) begin
            new_st    = ST_M;
            new_sh    = p_mask;
            new_mem   = req_data_p0;
            new_grant = GRANT_M;
        end else begin
            case (cur_st)
                ST_U: begin
                    new_st = ST_S;
                    new_sh = p_mask;
                end
                ST_S: begin
                    new_sh = cur_sh | p_mask;
                end
                ST_M: begin
                    if (peer_has) begin
                        new_st = ST_S;
                        new_sh = 2'b11;
                    end else begin
                        new_grant = GRANT_M;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (ReqValid) state_nx = LOOKUP;
            LOOKUP: begin
                if (illegal) state_nx = RESP;
                else if (msg_nx != MSG_NONE) state_nx = SEND_MSG;
                else state_nx = UPDATE;
            end
            SEND_MSG: state_nx = MsgAck ? UPDATE : WAIT_ACK;
            WAIT_ACK: if (MsgAck) state_nx = UPDATE;
            UPDATE:   state_nx = RESP;
            RESP:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        msg_on    = (state == SEND_MSG) || (state == WAIT_ACK);
        resp_on   = (state == RESP);
        ReqReady  = (state == IDLE);
        MsgValid  = msg_on;
        MsgType   = msg_on ? msg_type_p1 : 2'b00;
        MsgProc   = msg_on ? {1'b0, peer} : 2'b00;
        MsgAddr   = msg_on ? req_addr_p0 : 4'd0;
        RespValid = resp_on;
        RespProc  = resp_on ? req_proc_p0 : 2'b00;
        RespData  = resp_on ? resp_data : 4'd0;
        RespGrant = resp_on ? resp_grant : 2'b00;
        RespErr   = resp_on & err_p1;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            req_addr_p0 <= '0;
            req_data_p0 <= '0;
            req_op_p0   <= '0;
            req_proc_p0 <= '0;
            err_p1      <= 1'b0;
            msg_type_p1 <= MSG_NONE;
            cap_data_p2 <= '0;
            cap_vld_p2  <= 1'b0;
            resp_data   <= '0;
            resp_grant  <= '0;
            for (int i = 0; i < NBLK; i++) begin
                dstate[i]  <= ST_U;
                sharers[i] <= 2'b00;
                mem[i]     <= 4'd0;
            end
        end else begin
            state <= state_nx;
            case (state)
                // Accept: request fields frozen for the whole transaction
                IDLE: begin
                    if (ReqValid) begin
                        req_addr_p0 <= ReqAddr;
                        req_data_p0 <= ReqData;
                        req_op_p0   <= ReqOp;
                        req_proc_p0 <= ReqProc;
                        cap_vld_p2  <= 1'b0;
                    end
                end
                // Lookup: decide error/message, clear response payload
                LOOKUP: begin
                    err_p1      <= illegal;
                    msg_type_p1 <= illegal ? MSG_NONE : msg_nx;
                    resp_data   <= '0;
                    resp_grant  <= '0;
                end
                // Handshake: capture owner data with the ack
                SEND_MSG, WAIT_ACK: begin
                    if (MsgAck) begin
                        cap_data_p2 <= MsgData;
                        cap_vld_p2  <= 1'b1;
                    end
                end
                // Update: commit entry and response payload
                UPDATE: begin
                    dstate[idx]  <= new_st;
                    sharers[idx] <= new_sh;
                    mem[idx]     <= new_mem;
                    resp_data    <= new_mem;
                    resp_grant   <= new_grant;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_msi_directory_controller.sv
// Scoreboard bench for msi_directory_controller: directed requests push expected
// messages/responses; a negedge monitor pops and compares.
module tb_msi_directory_controller;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       ReqValid = 1'b0;
    logic       ReqReady;
    logic [3:0] ReqAddr = '0;
    logic [1:0] ReqOp = '0;
    logic [1:0] ReqProc = '0;
    logic [3:0] ReqData = '0;
    logic       MsgValid;
    logic [1:0] MsgType;
    logic [1:0] MsgProc;
    logic [3:0] MsgAddr;
    logic       MsgAck = 1'b0;
    logic [3:0] MsgData = '0;
    logic       RespValid;
    logic [1:0] RespProc;
    logic [3:0] RespData;
    logic [1:0] RespGrant;
    logic       RespErr;

    msi_directory_controller #(.NBLK(9)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr),
        .ReqOp(ReqOp), .ReqProc(ReqProc), .ReqData(ReqData),
        .MsgValid(MsgValid), .MsgType(MsgType), .MsgProc(MsgProc),
        .MsgAddr(MsgAddr), .MsgAck(MsgAck), .MsgData(MsgData),
        .RespValid(RespValid), .RespProc(RespProc), .RespData(RespData),
        .RespGrant(RespGrant), .RespErr(RespErr)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0] proc;
        logic [3:0] data;
        logic [1:0] grant;
        logic       err;
        int         cyc;
    } resp_t;

    typedef struct {
        logic [1:0] mtype;
        logic [1:0] proc;
        logic [3:0] addr;
        int         cyc;
    } msg_t;

    resp_t respq[$];
    msg_t  msgq[$];
    resp_t r;
    msg_t  m;
    msg_t  held;
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    int    rdy_cyc = -1;
    logic  msg_prev = 1'b0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: responses and messages against the scoreboard
    always @(negedge Clock) begin
        if (RespValid) begin
            if (respq.size() == 0) begin
                chk("resp_unexpected", 32'(RespValid), 32'd0);
            end else begin
                r = respq.pop_front();
                chk("resp_proc", 32'(RespProc), 32'(r.proc));
                chk("resp_data", 32'(RespData), 32'(r.data));
                chk("resp_grant", 32'(RespGrant), 32'(r.grant));
                chk("resp_err", 32'(RespErr), 32'(r.err));
                chk("resp_cycle", 32'(cyc), 32'(r.cyc));
                chk("ready_low_in_resp", 32'(ReqReady), 32'd0);
                rdy_cyc = cyc + 1;
            end
        end
        if (cyc == rdy_cyc) chk("ready_after_resp", 32'(ReqReady), 32'd1);
        if (MsgValid && !msg_prev) begin
            if (msgq.size() == 0) begin
                chk("msg_unexpected", 32'(MsgValid), 32'd0);
            end else begin
                m = msgq.pop_front();
                chk("msg_type", 32'(MsgType), 32'(m.mtype));
                chk("msg_proc", 32'(MsgProc), 32'(m.proc));
                chk("msg_addr", 32'(MsgAddr), 32'(m.addr));
                chk("msg_cycle", 32'(cyc), 32'(m.cyc));
            end
            held.mtype = MsgType;
            held.proc  = MsgProc;
            held.addr  = MsgAddr;
        end else if (MsgValid) begin
            chk("msg_stable", 32'({MsgType, MsgProc, MsgAddr}),
                32'({held.mtype, held.proc, held.addr}));
        end
        msg_prev = MsgValid;
    end

    task automatic junk_fields();
        ReqAddr = 4'hF;
        ReqOp   = 2'b11;
        ReqProc = 2'b11;
        ReqData = 4'hE;
    endtask

    task automatic wait_ready(output bit ok);
        int t = 0;
        @(negedge Clock);
        while (!ReqReady && t < 50) begin
            @(negedge Clock);
            t++;
        end
        ok = ReqReady;
        if (!ok) chk("ready_timeout", 32'(ReqReady), 32'd1);
    endtask

    task automatic wait_msg(output bit ok);
        int t = 0;
        while (!MsgValid && t < 20) begin
            @(negedge Clock);
            t++;
        end
        ok = MsgValid;
        if (!ok) chk("msg_timeout", 32'(MsgValid), 32'd1);
    endtask

    // One request; mtype != 0 means a message and ack are expected
    task automatic req(input logic [1:0] proc, input logic [1:0] op,
                       input logic [3:0] addr, input logic [3:0] data,
                       input logic [1:0] mtype, input int ackdly,
                       input logic [3:0] ackdata, input logic [3:0] edata,
                       input logic [1:0] egrant, input logic eerr,
                       input bit stray);
        bit    ok;
        int    n;
        resp_t er;
        msg_t  em;
        wait_ready(ok);
        if (!ok) return;
        ReqValid = 1'b1;
        ReqProc  = proc;
        ReqOp    = op;
        ReqAddr  = addr;
        ReqData  = data;
        n        = cyc;
        er.proc  = proc;
        er.data  = edata;
        er.grant = egrant;
        er.err   = eerr;
        if (mtype != 2'b00) begin
            em.mtype = mtype;
            em.proc  = {1'b0, ~proc[0]};
            em.addr  = addr;
            em.cyc   = n + 2;
            msgq.push_back(em);
        end else begin
            er.cyc = eerr ? n + 2 : n + 3;
            respq.push_back(er);
        end
        @(posedge Clock);
        #1;
        ReqValid = 1'b0;
        junk_fields();
        if (stray) begin
            MsgAck  = 1'b1;
            MsgData = 4'hA;
            @(posedge Clock);
            @(posedge Clock);
            #1;
            MsgAck  = 1'b0;
            MsgData = 4'h0;
        end
        if (mtype != 2'b00) begin
            @(negedge Clock);
            wait_msg(ok);
            if (!ok) return;
            for (int i = 0; i < ackdly; i++) begin
                if (ackdly >= 2 && i == 0) begin
                    ReqValid = 1'b1;
                    ReqAddr  = 4'd3;
                    ReqOp    = 2'b00;
                    ReqProc  = 2'b00;
                end else if (i == 1) begin
                    ReqValid = 1'b0;
                    junk_fields();
                end
                @(negedge Clock);
            end
            MsgAck  = 1'b1;
            MsgData = ackdata;
            er.cyc  = cyc + 2;
            respq.push_back(er);
            @(posedge Clock);
            #1;
            MsgAck  = 1'b0;
            MsgData = 4'h0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        msg_t em;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("rst_ready", 32'(ReqReady), 32'd1);
        chk("rst_outputs", 32'({MsgValid, MsgType, MsgProc, MsgAddr, RespValid,
                                RespProc, RespData, RespGrant, RespErr}), 32'd0);
        Reset = 1'b0;

        //  proc op  addr data  mtype dly ackd  edata grant err stray
        req(0, 0, 1, 0,  0, 0, 0,   0, 1, 0, 0);
        req(0, 0, 6, 0,  0, 0, 0,   0, 1, 0, 0);
        req(0, 1, 6, 7,  0, 0, 0,   7, 2, 0, 1);
        req(0, 0, 5, 0,  0, 0, 0,   0, 1, 0, 0);
        req(1, 0, 5, 0,  0, 0, 0,   0, 1, 0, 0);
        req(1, 1, 5, 8,  1, 3, 0,   8, 2, 0, 0);
        req(0, 1, 5, 9,  3, 1, 8,   9, 2, 0, 0);
        req(1, 0, 5, 0,  2, 0, 9,   9, 1, 0, 0);
        req(1, 1, 5, 4,  1, 0, 0,   4, 2, 0, 0);
        req(0, 0, 5, 0,  2, 2, 12, 12, 1, 0, 0);
        req(0, 0, 6, 0,  0, 0, 0,   7, 2, 0, 0);
        req(0, 1, 6, 3,  0, 0, 0,   3, 2, 0, 0);
        req(1, 1, 1, 2,  1, 2, 0,   2, 2, 0, 0);
        req(1, 1, 2, 5,  0, 0, 0,   5, 2, 0, 0);
        req(0, 0, 0, 0,  0, 0, 0,   0, 0, 1, 0);
        req(1, 1, 9, 15, 0, 0, 0,   0, 0, 1, 0);
        req(0, 2, 3, 6,  0, 0, 0,   0, 0, 1, 0);
        req(2, 0, 3, 0,  0, 0, 0,   0, 0, 1, 0);
        req(0, 0, 3, 0,  0, 0, 0,   0, 1, 0, 0);

        // Reset while waiting for the FetchInvalidate ack
        wait_ready(ok);
        if (ok) begin
            ReqValid = 1'b1;
            ReqProc  = 2'd0;
            ReqOp    = 2'd1;
            ReqAddr  = 4'd2;
            ReqData  = 4'd1;
            em.mtype = 2'b11;
            em.proc  = 2'd1;
            em.addr  = 4'd2;
            em.cyc   = cyc + 2;
            msgq.push_back(em);
            @(posedge Clock);
            #1;
            ReqValid = 1'b0;
            junk_fields();
            @(negedge Clock);
            wait_msg(ok);
            @(negedge Clock);
            Reset = 1'b1;
            @(posedge Clock);
            @(negedge Clock);
            chk("rst_mid_msgvalid", 32'(MsgValid), 32'd0);
            chk("rst_mid_respvalid", 32'(RespValid), 32'd0);
            chk("rst_mid_ready", 32'(ReqReady), 32'd1);
            chk("rst_mid_msgfields", 32'({MsgType, MsgProc, MsgAddr}), 32'd0);
            Reset = 1'b0;
        end

        req(1, 0, 2, 0,  0, 0, 0,   0, 1, 0, 0);
        req(0, 0, 5, 0,  0, 0, 0,   0, 1, 0, 0);
        req(1, 1, 6, 1,  0, 0, 0,   1, 2, 0, 0);

        repeat (10) @(negedge Clock);
        chk("respq_drained", 32'(respq.size()), 32'd0);
        chk("msgq_drained", 32'(msgq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
